// File: rtl/pixel_cell_serializer_pkg.sv
// Shared image-processing types: cell geometry, pixel/matrix types and the
// serializer state encoding.
package ImageProcessingPkg;

  localparam int CELL_DIM = 4;
  localparam int PIXEL_W  = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [CELL_DIM-1:0][CELL_DIM-1:0] pixelMatrix_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/pixel_cell_serializer.sv
// Captures one CELL_DIM x CELL_DIM pixel matrix and streams it out one pixel
// per beat in row-major order. A new cell can be taken on the final beat of
// the current one, so back-to-back cells stream without a bubble.
module pixel_cell_serializer
  import ImageProcessingPkg::ser_state_t;
  import ImageProcessingPkg::IDLE;
  import ImageProcessingPkg::SEND;
#(
  parameter int CELL_DIM = ImageProcessingPkg::CELL_DIM,
  parameter int PIXEL_W  = ImageProcessingPkg::PIXEL_W,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (CELL_DIM > 1) ? $clog2(CELL_DIM) : 1
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [CELL_DIM-1:0][CELL_DIM-1:0][PIXEL_W-1:0]   in_cell,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [PIXEL_W-1:0]                               out_pixel,
  output logic [IDX_W-1:0]                                 out_row,
  output logic [IDX_W-1:0]                                 out_col,
  output logic                                             out_last,
  output logic [CNT_W-1:0]                                 cells_done
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CELL_DIM - 1);

  ser_state_t                                          state_reg, state_next;
  logic [IDX_W-1:0]                                    row_reg, row_next;
  logic [IDX_W-1:0]                                    col_reg, col_next;
  logic [CELL_DIM-1:0][CELL_DIM-1:0][PIXEL_W-1:0]      buf_reg, buf_next;
  logic [CNT_W-1:0]                                    cnt_reg, cnt_next;
  logic                                                ready_en_reg;

  logic sending;
  logic at_last;
  logic beat;
  logic accept;

  // Output decode; in_ready is held low until the first edge after reset release.
  always_comb begin
    sending    = (state_reg == SEND);
    at_last    = sending && (row_reg == IDX_MAX) && (col_reg == IDX_MAX);
    out_valid  = sending;
    out_last   = at_last;
    out_row    = row_reg;
    out_col    = col_reg;
    out_pixel  = sending ? buf_reg[row_reg][col_reg] : '0;
    cells_done = cnt_reg;
    in_ready   = ready_en_reg && ((state_reg == IDLE) || (at_last && out_ready));
    beat       = sending && out_ready;
    accept     = in_valid && in_ready;
  end

  // Next-state: advance the row/col index on a beat, then let an accepted cell
  // override the index and state so a last-beat capture restarts at (0,0).
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    if (beat) begin
      if (at_last) begin
        cnt_next   = cnt_reg + CNT_W'(1);
        row_next   = '0;
        col_next   = '0;
        state_next = IDLE;
      end else if (col_reg == IDX_MAX) begin
        col_next = '0;
        row_next = row_reg + IDX_W'(1);
      end else begin
        col_next = col_reg + IDX_W'(1);
      end
    end
    if (accept) begin
      buf_next   = in_cell;
      row_next   = '0;
      col_next   = '0;
      state_next = SEND;
    end
  end

  // State, index, capture buffer and counter registers; reset drops any partial cell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      buf_reg      <= '0;
      cnt_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      buf_reg      <= buf_next;
      cnt_reg      <= cnt_next;
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_cell_serializer.sv
// Directed bench for pixel_cell_serializer: reset, single cell, backpressure,
// back-to-back cells, reset mid-cell and cells_done wrap (CNT_W=4).
module tb_pixel_cell_serializer;
  import ImageProcessingPkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  pixelMatrix_t in_cell;
  logic         out_valid;
  logic         out_ready;
  logic [23:0]  out_pixel;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         out_last;
  logic [3:0]   cells_done;

  int vectors    = 0;
  int miscompares = 0;

  pixelMatrix_t cell_a, cell_b, cell_g, cell_c, cell_d, cell_idx;

  always #5 clk = ~clk;

  pixel_cell_serializer #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cell    (in_cell),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .cells_done (cells_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept cell c with out_ready=1 and check all CELL_DIM^2 beats in order.
  task automatic send_cell(input pixelMatrix_t c, input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_cell   = c;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_cell  = ~c;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pixel"}, 32'(out_pixel), 32'(c[k/4][k%4]));
      chk({tag, "_row"},   32'(out_row),   32'(k/4));
      chk({tag, "_col"},   32'(out_col),   32'(k%4));
      chk({tag, "_last"},  32'(out_last),  32'(k == 15));
      $display("%s beat %0d row=%0d col=%0d pixel=%06h last=%0d",
               tag, k, out_row, out_col, out_pixel, out_last);
      @(negedge clk);
    end
    #1 chk({tag, "_idle_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cell_idx[i][j] = (24'(i) << 20) | (24'(j) << 16) | 24'(i * 4 + j + 1);
        cell_a[i][j]   = 24'hFF0000;
        cell_b[i][j]   = 24'h0000FF;
        cell_g[i][j]   = 24'h00FF00;
        cell_c[i][j]   = 24'h123456 + 24'(i * 4 + j);
        cell_d[i][j]   = 24'hFFFFFF;
      end

    // 1: reset
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_cell   = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_out_pixel",  32'(out_pixel),  32'd0);
    chk("rst_cells_done", 32'(cells_done), 32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    $display("reset: valid=%0d last=%0d pixel=%06h done=%0d ready=%0d",
             out_valid, out_last, out_pixel, cells_done, in_ready);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready",   32'(in_ready),   32'd1);
    chk("post_rst_cells_done", 32'(cells_done), 32'd0);
    chk("post_rst_out_valid",  32'(out_valid),  32'd0);

    // 2: single cell with indexed pixels
    send_cell(cell_idx, "single");
    chk("single_cells_done", 32'(cells_done), 32'd1);

    // 3: backpressure, out_ready toggling
    begin
      int beat_n;
      int cyc;
      @(negedge clk);
      in_valid  = 1'b1;
      in_cell   = cell_g;
      out_ready = 1'b0;
      #1 chk("bp_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_cell  = '1;
      beat_n = 0;
      cyc    = 0;
      while (beat_n < 16 && cyc < 200) begin
        out_ready = cyc[0];
        #1;
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_pixel",    32'(out_pixel), 32'h00FF00);
        chk("bp_row",      32'(out_row),   32'(beat_n / 4));
        chk("bp_col",      32'(out_col),   32'(beat_n % 4));
        chk("bp_last",     32'(out_last),  32'(beat_n == 15));
        chk("bp_in_ready", 32'(in_ready),  32'(beat_n == 15 && cyc[0]));
        $display("bp cyc %0d ready=%0d row=%0d col=%0d pixel=%06h last=%0d",
                 cyc, out_ready, out_row, out_col, out_pixel, out_last);
        if (cyc[0]) beat_n++;
        cyc++;
        @(negedge clk);
      end
      chk("bp_beats_total", 32'(beat_n), 32'd16);
      #1;
      chk("bp_idle_after",  32'(out_valid),  32'd0);
      chk("bp_cells_done",  32'(cells_done), 32'd2);
    end

    // 4: back-to-back cells, no bubble
    @(negedge clk);
    in_valid  = 1'b1;
    in_cell   = cell_a;
    out_ready = 1'b1;
    @(negedge clk);
    in_cell = cell_b;
    for (int k = 0; k < 32; k++) begin
      in_valid = (k <= 15);
      #1;
      chk("b2b_valid",    32'(out_valid), 32'd1);
      chk("b2b_pixel",    32'(out_pixel), (k < 16) ? 32'hFF0000 : 32'h0000FF);
      chk("b2b_row",      32'(out_row),   32'((k % 16) / 4));
      chk("b2b_col",      32'(out_col),   32'(k % 4));
      chk("b2b_last",     32'(out_last),  32'(k % 16 == 15));
      chk("b2b_in_ready", 32'(in_ready),  32'(k == 15 || k == 31));
      $display("b2b beat %0d row=%0d col=%0d pixel=%06h last=%0d",
               k, out_row, out_col, out_pixel, out_last);
      @(negedge clk);
    end
    #1;
    chk("b2b_idle_after", 32'(out_valid),  32'd0);
    chk("b2b_cells_done", 32'(cells_done), 32'd4);

    // 5: reset mid-cell at beat 7
    @(negedge clk);
    in_valid  = 1'b1;
    in_cell   = cell_c;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1 chk("mid_pixel", 32'(out_pixel), 32'(cell_c[k/4][k%4]));
      @(negedge clk);
    end
    #1;
    chk("mid_beat7_col", 32'(out_col), 32'd3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid),  32'd0);
    chk("mid_rst_last",  32'(out_last),   32'd0);
    chk("mid_rst_pixel", 32'(out_pixel),  32'd0);
    chk("mid_rst_done",  32'(cells_done), 32'd0);
    $display("mid reset: valid=%0d last=%0d pixel=%06h done=%0d",
             out_valid, out_last, out_pixel, cells_done);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_cell(cell_d, "after_rst");
    chk("after_rst_cells_done", 32'(cells_done), 32'd1);

    // 6: wrap of the 4-bit cells_done counter
    for (int n = 0; n < 14; n++) send_cell(cell_idx, "wrap_fill");
    chk("wrap_at_15", 32'(cells_done), 32'd15);
    send_cell(cell_b, "wrap_last");
    chk("wrap_to_0", 32'(cells_done), 32'd0);
    $display("wrap: cells_done=%0d", cells_done);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
